// File: rtl/dma_arb_pkg.sv
// Shared types for the DMA job arbiter: FSM states, cache-line counts and requester indices.
package dma_arb_pkg;

  localparam int CL_ADDR_WIDTH = 58;
  localparam int MAX_REQ       = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GO,
    ST_ARM,
    ST_BUSY,
    ST_FIN
  } arb_state_t;

  typedef logic [CL_ADDR_WIDTH:0]       count_t;
  typedef logic [$clog2(MAX_REQ)-1:0]   req_idx_t;

endpackage

// File: rtl/dma_if.sv
// AFU DMA channel: job launch, address/size, and the streaming read/write FIFOs.
interface dma_if
  import dma_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int SIZE_WIDTH = CL_ADDR_WIDTH + 1,
  parameter int DATA_WIDTH = 512
);

  logic                  rd_go;
  logic                  wr_go;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [SIZE_WIDTH-1:0] rd_size;
  logic [SIZE_WIDTH-1:0] wr_size;
  logic                  rd_en;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  empty;
  logic                  full;
  logic                  rd_done;
  logic                  wr_done;

  // The job issuer (arbiter) side; master is an alias of peripheral.
  modport peripheral (
    output rd_go, wr_go, rd_addr, wr_addr, rd_size, wr_size, rd_en, wr_en, wr_data,
    input  rd_data, empty, full, rd_done, wr_done
  );

  modport master (
    output rd_go, wr_go, rd_addr, wr_addr, rd_size, wr_size, rd_en, wr_en, wr_data,
    input  rd_data, empty, full, rd_done, wr_done
  );

  modport slave (
    input  rd_go, wr_go, rd_addr, wr_addr, rd_size, wr_size, rd_en, wr_en, wr_data,
    output rd_data, empty, full, rd_done, wr_done
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: lowest requesting index at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int i = 0; i < N; i++) begin
      int k;
      k = int'(ptr) + i;
      if (k >= N) k = k - N;
      if (!any && req[k]) begin
        any      = 1'b1;
        grant[k] = 1'b1;
        idx      = IW'(k);
      end
    end
  end

endmodule

// File: rtl/dma_job_arbiter.sv
// Shares one AFU DMA channel among NUM_REQ requesters: round-robin job grant,
// launch, per-owner data routing and completion reporting.
module dma_job_arbiter
  import dma_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 64,
  parameter int SIZE_WIDTH = $bits(count_t),
  parameter int DATA_WIDTH = 512
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_REQ-1:0]                   req_valid,
  input  logic [NUM_REQ-1:0]                   req_write,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ-1:0][SIZE_WIDTH-1:0]   req_size,
  output logic [NUM_REQ-1:0]                   req_ack,
  output logic [NUM_REQ-1:0]                   req_done,
  output logic [NUM_REQ-1:0]                   rd_valid,
  input  logic [NUM_REQ-1:0]                   rd_en,
  output logic [DATA_WIDTH-1:0]                rd_data,
  output logic [NUM_REQ-1:0]                   wr_full,
  input  logic [NUM_REQ-1:0]                   wr_en,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   wr_data,
  output logic                                 busy,
  dma_if.peripheral                            dma
);

  localparam int IW = $clog2(NUM_REQ);

  arb_state_t            state_q, state_d;
  logic [IW-1:0]         ptr_q, ptr_d;
  logic [IW-1:0]         owner_q, owner_d;
  logic                  write_q, write_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [SIZE_WIDTH-1:0] size_q, size_d;

  logic [NUM_REQ-1:0]    grant;
  logic [IW-1:0]         grant_idx;
  logic                  grant_any;

  logic                  rd_go, wr_go, dma_rd_en, dma_wr_en;

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx);
    return (idx == IW'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
  endfunction

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req   (req_valid),
    .ptr   (ptr_q),
    .grant (grant),
    .idx   (grant_idx),
    .any   (grant_any)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    write_d   = write_q;
    addr_d    = addr_q;
    size_d    = size_q;
    req_ack   = '0;
    req_done  = '0;
    rd_valid  = '0;
    wr_full   = '1;
    rd_go     = 1'b0;
    wr_go     = 1'b0;
    dma_rd_en = 1'b0;
    dma_wr_en = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Acks are suppressed while reset is held so nothing is accepted in reset.
        if (grant_any && !rst) begin
          req_ack = grant;
          if (req_size[grant_idx] == '0) begin
            req_done = grant;
            ptr_d    = next_idx(grant_idx);
          end else begin
            owner_d = grant_idx;
            write_d = req_write[grant_idx];
            addr_d  = req_addr[grant_idx];
            size_d  = req_size[grant_idx];
            state_d = ST_GO;
          end
        end
      end
      ST_GO: begin
        rd_go   = ~write_q;
        wr_go   = write_q;
        state_d = ST_ARM;
      end
      ST_ARM: begin
        // Done flags still reflect the previous job here; ignore them.
        state_d = ST_BUSY;
      end
      ST_BUSY: begin
        rd_valid[owner_q] = ~dma.empty;
        wr_full[owner_q]  = dma.full;
        dma_rd_en         = rd_en[owner_q] & ~dma.empty;
        dma_wr_en         = wr_en[owner_q] & ~dma.full;
        if (write_q ? dma.wr_done : dma.rd_done) state_d = ST_FIN;
      end
      ST_FIN: begin
        req_done[owner_q] = 1'b1;
        ptr_d             = next_idx(owner_q);
        state_d           = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      size_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
    end
  end

  assign dma.rd_go   = rd_go;
  assign dma.wr_go   = wr_go;
  assign dma.rd_en   = dma_rd_en;
  assign dma.wr_en   = dma_wr_en;
  assign dma.rd_addr = addr_q;
  assign dma.wr_addr = addr_q;
  assign dma.rd_size = size_q;
  assign dma.wr_size = size_q;
  assign dma.wr_data = wr_data[owner_q];
  assign rd_data     = dma.rd_data;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dma_job_arbiter.sv
// Bench for dma_job_arbiter: directed scenarios plus randomized traffic against a
// job-level reference model, with a DMA engine model driving the channel.
module tb_dma_job_arbiter;
  import dma_arb_pkg::*;

  localparam int N  = 4;
  localparam int AW = 64;
  localparam int SW = CL_ADDR_WIDTH + 1;
  localparam int DW = 512;

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0]         req_valid, req_write, req_ack, req_done, rd_valid, rd_en, wr_full, wr_en;
  logic [N-1:0][AW-1:0] req_addr;
  logic [N-1:0][SW-1:0] req_size;
  logic [N-1:0][DW-1:0] wr_data;
  logic [DW-1:0]        rd_data;
  logic                 busy;

  dma_if #(.ADDR_WIDTH(AW), .SIZE_WIDTH(SW), .DATA_WIDTH(DW)) dma ();

  dma_job_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .SIZE_WIDTH(SW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_size(req_size), .req_ack(req_ack), .req_done(req_done),
    .rd_valid(rd_valid), .rd_en(rd_en), .rd_data(rd_data), .wr_full(wr_full),
    .wr_en(wr_en), .wr_data(wr_data), .busy(busy), .dma(dma)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // reference model: job-level view (accepted job, cycles since accept, completion pending)
  bit            m_active, m_fin, m_write;
  int            m_age, m_owner, m_ptr;
  logic [AW-1:0] m_addr;
  logic [SW-1:0] m_size;

  // DMA engine model
  bit            e_pend, e_run, e_write;
  int            e_left;
  logic          nx_rd_done, nx_wr_done, nx_empty, nx_full;
  logic [DW-1:0] nx_rd_data;

  // snapshots of DUT outputs at the last sample point
  logic [N-1:0]  s_ack, s_done, s_rd_valid, s_wr_full, s_xack;
  logic          s_busy, s_rd_go, s_wr_go, s_dma_rd_en, s_dma_wr_en;
  logic [AW-1:0] s_rd_addr;
  int            pop_cnt[N];
  int            done_cnt[N];
  int            ack_log[$];
  int            cyc_no = 0;
  bit            rand_dp, rand_req;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc_no);
    end
  endtask

  function automatic logic [DW-1:0] rnd();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int i = 0; i < N; i++) begin
      if (v[(p + i) % N]) return (p + i) % N;
    end
    return -1;
  endfunction

  task automatic check_cycle();
    logic [N-1:0] x_ack, x_done, x_rdv, x_wf;
    logic         x_rgo, x_wgo, x_drd, x_dwr, x_busy;
    bit           in_busy;
    int           g;
    x_ack = '0; x_done = '0; x_rdv = '0; x_wf = '1;
    x_rgo = 0; x_wgo = 0; x_drd = 0; x_dwr = 0; x_busy = 0; in_busy = 0; g = -1;
    if (rst) begin
      m_active = 0; m_fin = 0; m_ptr = 0; m_addr = '0; m_size = '0; m_age = 0;
    end else if (!m_active) begin
      g = pick(req_valid, m_ptr);
      if (g >= 0) begin
        x_ack[g] = 1'b1;
        if (req_size[g] == '0) x_done[g] = 1'b1;
      end
    end else begin
      x_busy = 1'b1;
      if (m_fin) x_done[m_owner] = 1'b1;
      else if (m_age == 1) begin x_rgo = !m_write; x_wgo = m_write; end
      else if (m_age >= 3) in_busy = 1;
    end
    if (in_busy) begin
      x_rdv[m_owner] = ~dma.empty;
      x_wf[m_owner]  = dma.full;
      x_drd = rd_en[m_owner] & ~dma.empty;
      x_dwr = wr_en[m_owner] & ~dma.full;
      chk("dma_wr_data", dma.wr_data, wr_data[m_owner]);
    end
    chk("req_ack", req_ack, x_ack);
    chk("req_done", req_done, x_done);
    chk("busy", busy, x_busy);
    chk("rd_go", dma.rd_go, x_rgo);
    chk("wr_go", dma.wr_go, x_wgo);
    chk("rd_valid", rd_valid, x_rdv);
    chk("wr_full", wr_full, x_wf);
    chk("dma_rd_en", dma.rd_en, x_drd);
    chk("dma_wr_en", dma.wr_en, x_dwr);
    chk("rd_addr", dma.rd_addr, m_addr);
    chk("wr_addr", dma.wr_addr, m_addr);
    chk("rd_size", dma.rd_size, m_size);
    chk("wr_size", dma.wr_size, m_size);
    chk("rd_data", rd_data, dma.rd_data);

    s_ack = req_ack; s_done = req_done; s_rd_valid = rd_valid; s_wr_full = wr_full;
    s_busy = busy; s_rd_go = dma.rd_go; s_wr_go = dma.wr_go;
    s_dma_rd_en = dma.rd_en; s_dma_wr_en = dma.wr_en; s_rd_addr = dma.rd_addr;
    s_xack = x_ack;
    for (int i = 0; i < N; i++) begin
      if (req_ack[i]) ack_log.push_back(i);
      pop_cnt[i]  += int'(rd_valid[i] & rd_en[i]);
      done_cnt[i] += int'(req_done[i]);
    end

    if (!rst) begin
      if (!m_active) begin
        if (g >= 0) begin
          if (req_size[g] == '0) m_ptr = (g + 1) % N;
          else begin
            m_active = 1; m_fin = 0; m_age = 1; m_owner = g;
            m_write = req_write[g]; m_addr = req_addr[g]; m_size = req_size[g];
          end
        end
      end else if (m_fin) begin
        m_active = 0; m_fin = 0; m_ptr = (m_owner + 1) % N;
      end else if (m_age < 3) begin
        m_age++;
      end else if (m_write ? dma.wr_done : dma.rd_done) begin
        m_fin = 1;
      end
    end
  endtask

  task automatic engine_step();
    if (rst) begin
      e_pend = 0; e_run = 0; e_left = 0;
      nx_rd_done = 1; nx_wr_done = 1;
    end else if (dma.rd_go || dma.wr_go) begin
      e_pend = 1; e_write = dma.wr_go;
      e_left = dma.wr_go ? int'(dma.wr_size) : int'(dma.rd_size);
    end else if (e_pend) begin
      // done stays high through the ARM cycle, then clears
      e_pend = 0; e_run = 1;
      if (e_write) nx_wr_done = 0; else nx_rd_done = 0;
    end else if (e_run) begin
      if (!e_write && dma.rd_en && !dma.empty) e_left--;
      if (e_write && dma.wr_en && !dma.full) e_left--;
      if (e_left <= 0) begin
        e_run = 0;
        if (e_write) nx_wr_done = 1; else nx_rd_done = 1;
      end
    end
    nx_empty   = !(e_run && !e_write && e_left > 0) || ($urandom % 4 == 0);
    nx_full    = !(e_run && e_write && e_left > 0) || ($urandom % 4 == 0);
    nx_rd_data = rnd();
  endtask

  task automatic cyc();
    @(negedge clk);
    check_cycle();
    engine_step();
    @(posedge clk);
    #1;
    cyc_no++;
    dma.rd_done = nx_rd_done; dma.wr_done = nx_wr_done;
    dma.empty = nx_empty; dma.full = nx_full; dma.rd_data = nx_rd_data;
    req_valid = req_valid & ~s_xack;
    if (rand_dp) begin
      rd_en = N'($urandom); wr_en = N'($urandom);
      for (int i = 0; i < N; i++) wr_data[i] = rnd();
    end
    if (rand_req) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && ($urandom % 5 == 0)) begin
          req_valid[i] = 1'b1;
          req_write[i] = 1'($urandom);
          req_addr[i]  = {$urandom, $urandom};
          req_size[i]  = SW'($urandom % 6);
        end
      end
    end
  endtask

  task automatic wait_idle(input int bound);
    int k = 0;
    while ((m_active || req_valid != '0) && k < bound) begin cyc(); k++; end
    if (m_active || req_valid != '0) begin
      n_vec++; n_bad++;
      $display("FAIL idle_timeout: still busy after %0d cycles", bound);
    end
  endtask

  task automatic set_job(input int i, input logic w, input logic [AW-1:0] a, input int sz);
    req_write[i] = w; req_addr[i] = a; req_size[i] = SW'(sz); req_valid[i] = 1'b1;
  endtask

  task automatic clear_cnt();
    for (int i = 0; i < N; i++) begin pop_cnt[i] = 0; done_cnt[i] = 0; end
    ack_log.delete();
  endtask

  initial begin
    int k, ack0_cyc, done3_cyc;
    bit rereq;
    rst = 1; rand_dp = 1; rand_req = 0;
    req_valid = '0; req_write = '0; rd_en = '0; wr_en = '0;
    for (int i = 0; i < N; i++) begin req_addr[i] = '0; req_size[i] = '0; wr_data[i] = rnd(); end
    dma.rd_done = 1; dma.wr_done = 1; dma.empty = 1; dma.full = 1; dma.rd_data = '0;
    nx_rd_done = 1; nx_wr_done = 1; nx_empty = 1; nx_full = 1; nx_rd_data = '0;
    e_pend = 0; e_run = 0; e_write = 0; e_left = 0;
    m_active = 0; m_fin = 0; m_ptr = 0; m_age = 0; m_owner = 0; m_write = 0;
    m_addr = '0; m_size = '0;

    // contention: all four valid across reset release
    for (int i = 0; i < N; i++) set_job(i, 1'b0, AW'(64'h100 * (i + 1)), 1);
    cyc(); cyc();
    chk("rst_ack", s_ack, 4'b0000);
    chk("rst_busy", s_busy, 1'b0);
    chk("rst_wr_full", s_wr_full, 4'b1111);
    rst = 0;
    clear_cnt();
    rereq = 0; ack0_cyc = -1; done3_cyc = -1; k = 0;
    while (ack_log.size() < 5 && k < 300) begin
      cyc(); k++;
      if (s_done[3] && done3_cyc < 0) done3_cyc = cyc_no;
      if (s_ack[0] && rereq) ack0_cyc = cyc_no;
      if (s_ack[0] && !rereq) begin req_valid[0] = 1'b1; rereq = 1; end
    end
    if (ack_log.size() < 5) begin
      n_vec++; n_bad++;
      $display("FAIL contention_timeout: %0d grants seen, 5 required", ack_log.size());
    end else begin
      chk("grant_order0", ack_log[0], 0);
      chk("grant_order1", ack_log[1], 1);
      chk("grant_order2", ack_log[2], 2);
      chk("grant_order3", ack_log[3], 3);
      chk("grant_order4", ack_log[4], 0);
      chk("regrant_after_3done", (ack0_cyc > done3_cyc && done3_cyc > 0), 1'b1);
    end
    wait_idle(200);

    // single read job from requester 2
    rand_dp = 0; rd_en = 4'b0100; wr_en = '0;
    clear_cnt();
    set_job(2, 1'b0, 64'h1000, 4);
    cyc();
    chk("read_ack", s_ack, 4'b0100);
    cyc();
    chk("read_go", s_rd_go, 1'b1);
    chk("read_go_addr", s_rd_addr, 64'h1000);
    chk("read_go_size", dma.rd_size, 4);
    for (int i = 0; i < 40; i++) cyc();
    chk("read_pops", pop_cnt[2], 4);
    chk("read_done_once", done_cnt[2], 1);

    // write job while wr_done is still high from earlier
    clear_cnt();
    wr_en = 4'b0010;
    set_job(1, 1'b1, 64'h2000, 2);
    cyc();
    cyc();
    chk("stale_go", s_wr_go, 1'b1);
    chk("stale_no_done_go", s_done, 4'b0000);
    cyc();
    chk("stale_no_done_arm", s_done, 4'b0000);
    for (int i = 0; i < 40; i++) cyc();
    chk("stale_done_once", done_cnt[1], 1);

    // isolation: requester 0 pokes the data path during requester 1's read
    rd_en = 4'b0001; wr_en = 4'b0001;
    set_job(1, 1'b0, 64'h3000, 3);
    cyc(); cyc(); cyc(); cyc();
    chk("iso_dma_rd_en", s_dma_rd_en, 1'b0);
    chk("iso_dma_wr_en", s_dma_wr_en, 1'b0);
    chk("iso_rd_valid0", s_rd_valid[0], 1'b0);
    chk("iso_wr_full0", s_wr_full[0], 1'b1);
    rd_en = 4'b0011;
    wait_idle(100);
    for (int i = 0; i < 3; i++) cyc();

    // zero-size job from requester 3 wraps ptr to 0
    set_job(3, 1'b0, 64'h4000, 0);
    cyc();
    chk("zero_ack", s_ack, 4'b1000);
    chk("zero_done", s_done, 4'b1000);
    cyc();
    chk("zero_no_busy", s_busy, 1'b0);
    chk("zero_no_go", {s_rd_go, s_wr_go}, 2'b00);
    rd_en = '1;
    set_job(3, 1'b0, 64'h4100, 1);
    set_job(0, 1'b0, 64'h4200, 1);
    cyc();
    chk("zero_ptr_wrap", s_ack, 4'b0001);
    wait_idle(200);
    for (int i = 0; i < 3; i++) cyc();

    // reset mid-BUSY: ptr must come back to 0
    set_job(1, 1'b0, 64'h5000, 1);
    wait_idle(100);
    for (int i = 0; i < 3; i++) cyc();
    rd_en = '0;
    set_job(2, 1'b0, 64'h6000, 5);
    for (int i = 0; i < 5; i++) cyc();
    rst = 1;
    cyc();
    chk("midrst_busy", s_busy, 1'b0);
    chk("midrst_rd_valid", s_rd_valid, 4'b0000);
    chk("midrst_wr_full", s_wr_full, 4'b1111);
    chk("midrst_addr", s_rd_addr, 64'h0);
    rst = 0;
    clear_cnt();
    rd_en = '1;
    set_job(1, 1'b0, 64'h7000, 1);
    set_job(3, 1'b0, 64'h7100, 1);
    cyc();
    chk("midrst_regrant", s_ack, 4'b0010);
    wait_idle(200);
    chk("midrst_no_done2", done_cnt[2], 0);

    // randomized traffic
    rand_dp = 1; rand_req = 1;
    for (int i = 0; i < 2500; i++) begin
      cyc();
      if (i == 1200) begin rst = 1; cyc(); rst = 0; end
    end
    rand_req = 0;
    wait_idle(1000);
    for (int i = 0; i < 5; i++) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
